multiply_128: RTL and testbench
===============================

// Module: multiply_128
// PURPOSE
//   Sequential signed fixed-point multiplier; the inverse operation of divide_128.
//   Radix-2 shift-add on operand magnitudes, then sign restore, then round-half-even on dropped fraction bits.
//   Feeds the H-infinity matrix datapath (gain/Riccati products) with one multiply every WIDTH+4 cycles.
//   Operands and result share one Q format: WIDTH bits, two's complement, FRAC fraction bits.
// PARAMETERS
//   WIDTH  128  operand/result width in bits, including the sign bit
//   FRAC   70   fraction bits of the Q format, where 0 < FRAC < WIDTH-1
// PORTS
//   clk    in   1      single clock; all state updates on its rising edge
//   rst    in   1      synchronous active-high reset
//   Start  in   1      request; sampled only in IDLE
//   X      in   WIDTH  signed multiplicand; captured on the accepted Start edge
//   Y      in   WIDTH  signed multiplier; captured on the accepted Start edge
//   P      out  WIDTH  signed product; held until the next RESULT
//   Busy   out  1      high from LOAD through RESULT
//   Done   out  1      one-cycle pulse when P updates
//   Ovf    out  1      product out of range; valid with Done, held with P
// BEHAVIOUR
//   Reset: P=0, Done=0, Busy=0, Ovf=0, state=IDLE, counter=0.
//   Reset mid-operation aborts the operation at the next edge. Captured operands are discarded.
//   FSM: IDLE -> LOAD -> CAL -> RND -> RESULT -> IDLE.
//   IDLE: on Start=1, register Xs^Ys as the result sign, and |X|,|Y| as WIDTH-bit magnitudes.
//     -2^(WIDTH-1) is therefore exact: its magnitude is 2^(WIDTH-1).
//   LOAD: clear the 2*WIDTH-bit accumulator; load the multiplier shift register with |Y|.
//   CAL: exactly WIDTH iterations, counter 0..WIDTH-1.
//     Each iteration: if the multiplier LSB is 1, add |X| into the upper half of the accumulator.
//     Then shift {carry, acc, mult} right by 1.
//   RND: form M = acc >> FRAC.
//     G = acc[FRAC-1]; S = OR(acc[FRAC-2:0]).
//     M += G & (S | M[0]), i.e. round half to even in magnitude.
//   RESULT: Ovf = (M > 2^(WIDTH-1)-1) or (M == 2^(WIDTH-1) and sign positive).
//     P = sign ? -M : M; a zero magnitude always gives P=0 (no negative zero).
//     Done=1 for this cycle only. Return to IDLE.
//   Latency: Start sampled at edge 0; Done and P valid after edge WIDTH+3 (edge 131 for WIDTH=128).
//   Start while Busy, or in the RESULT cycle, is ignored. It is not queued.
//   X, Y may change freely after the accepted Start edge.
//   X=0 or Y=0 follows the normal path: P=0, Ovf=0, same latency.
// CONFIGURATION
//   MUL128_SAT_EN defined: on Ovf, P saturates to 2^(WIDTH-1)-1 or -2^(WIDTH-1) according to the sign.
//   MUL128_SAT_EN undefined: on Ovf, P = low WIDTH bits of the signed rounded result (wrap).
//   Ovf is reported in both builds.
// STRUCTURE
//   Package h_inf_fxp_pkg: WIDTH/FRAC defaults, FSM state encoding (IDLE..RESULT), Q-format helper constants.
//     The helper constants are ONE = 1<<FRAC, MAX_POS, MIN_NEG.
//   Sub-module fxp_round_sat (combinational): acc, sign -> P, Ovf.
//     It implements RND/RESULT math and the MUL128_SAT_EN option; reusable by divide_128 follow-ons.
//   Top holds the FSM, counter, operand and accumulator registers.
// TESTING
//   1) X=Y=2^70 (1.0*1.0), Start one cycle -> Done at edge 131, P=2^70, Ovf=0, Busy high edges 1..130.
//   2) X=-(3*2^69), Y=2^71 (-1.5*2.0) -> P=-(3*2^70), Ovf=0.
//      Also X=-2^127, Y=2^70 -> P=-2^127, Ovf=0.
//   3) Ties: X=1, Y=2^69 -> P=0; X=3, Y=2^69 -> P=2. Non-tie: X=1, Y=2^69+1 -> P=1.
//      Signed: X=-3, Y=2^69 -> P=-2.
//   4) X=Y=2^120 -> Ovf=1.
//      SAT_EN build: P=2^127-1; with X negated, P=-2^127.
//      Non-SAT build: P equals the reference-model wrap value.
//   5) rst=1 for one cycle at CAL iteration 50 -> next cycle Busy=0, Done=0, P=0.
//      A following Start(X=Y=2^70) -> P=2^70.
//   6) Start held high for 300 cycles with operands changing each cycle -> exactly two Done pulses.
//      Each P matches the operands of its own accepted Start (edges 0 and 132).
//      X=0, Y=-5 -> P=0.

Source files
------------

// File: rtl/h_inf_fxp_pkg.sv
// Shared fixed-point definitions for the H-infinity datapath: default Q format,
// multiplier FSM encoding and Q-format helper constants.
package h_inf_fxp_pkg;

    localparam int WIDTH_DEF = 128;
    localparam int FRAC_DEF  = 70;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CAL    = 3'd2,
        RND    = 3'd3,
        RESULT = 3'd4
    } state_t;

    localparam logic [WIDTH_DEF-1:0] ONE     = {{(WIDTH_DEF-FRAC_DEF-1){1'b0}}, 1'b1, {FRAC_DEF{1'b0}}};
    localparam logic [WIDTH_DEF-1:0] MAX_POS = {1'b0, {(WIDTH_DEF-1){1'b1}}};
    localparam logic [WIDTH_DEF-1:0] MIN_NEG = {1'b1, {(WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/fxp_round_sat.sv
// Round-half-even of a double-width magnitude back to the Q format, sign restore
// and range check. MUL128_SAT_EN selects saturation instead of wrap on overflow.
module fxp_round_sat
    import h_inf_fxp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic               sign,
    output logic [WIDTH-1:0]   p,
    output logic               ovf
);

    localparam int MW = 2*WIDTH - FRAC;
    localparam logic [MW-1:0]    HALF_RANGE = {{(MW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SAT_POS    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG    = {1'b1, {(WIDTH-1){1'b0}}};

    logic [MW-1:0]    trunc_s;
    logic [MW-1:0]    mag_s;
    logic             guard_s;
    logic             sticky_s;
    logic [WIDTH-1:0] wrap_s;

    // Round the magnitude, then restore the sign; negating zero yields zero.
    always_comb begin
        trunc_s  = acc[2*WIDTH-1:FRAC];
        guard_s  = acc[FRAC-1];
        sticky_s = |acc[FRAC-2:0];
        mag_s    = trunc_s + {{(MW-1){1'b0}}, guard_s & (sticky_s | trunc_s[0])};
        ovf      = (mag_s > HALF_RANGE) || ((mag_s == HALF_RANGE) && !sign);
        if (sign) begin
            wrap_s = ~mag_s[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            wrap_s = mag_s[WIDTH-1:0];
        end
`ifdef MUL128_SAT_EN
        if (ovf) begin
            p = sign ? SAT_NEG : SAT_POS;
        end else begin
            p = wrap_s;
        end
`else
        p = wrap_s;
`endif
    end

endmodule

// File: rtl/multiply_128.sv
// Sequential signed Q-format multiplier: radix-2 shift-add on magnitudes, then
// round/sign/range via fxp_round_sat. Overflow policy follows MUL128_SAT_EN.
module multiply_128
    import h_inf_fxp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] P,
    output logic             Busy,
    output logic             Done,
    output logic             Ovf
);

    localparam int CW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic               sign_r;
    logic [WIDTH-1:0]   mx_r;
    logic [WIDTH-1:0]   mult_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   rnd_p_r;
    logic               rnd_ovf_r;

    logic [WIDTH-1:0]   addend_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   rs_p_s;
    logic               rs_ovf_s;

    // Conditional add of |X| into the upper accumulator half, keeping the carry.
    always_comb begin
        addend_s = {WIDTH{1'b0}};
        if (mult_r[0]) begin
            addend_s = mx_r;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
    end

    fxp_round_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_round_sat (
        .acc  (acc_r),
        .sign (sign_r),
        .p    (rs_p_s),
        .ovf  (rs_ovf_s)
    );

    // Control FSM, operand/accumulator datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            sign_r    <= 1'b0;
            mx_r      <= {WIDTH{1'b0}};
            mult_r    <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            rnd_p_r   <= {WIDTH{1'b0}};
            rnd_ovf_r <= 1'b0;
            P         <= {WIDTH{1'b0}};
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Ovf       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (Start) begin
                        sign_r  <= X[WIDTH-1] ^ Y[WIDTH-1];
                        mx_r    <= magnitude(X);
                        mult_r  <= magnitude(Y);
                        Busy    <= 1'b1;
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    acc_r   <= {(2*WIDTH){1'b0}};
                    cnt_r   <= {CW{1'b0}};
                    state_r <= CAL;
                end
                CAL: begin
                    // Product bits fall out of the upper half into the lower half.
                    acc_r  <= {sum_s, acc_r[WIDTH-1:1]};
                    mult_r <= {1'b0, mult_r[WIDTH-1:1]};
                    if (cnt_r == CW'(WIDTH-1)) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= RND;
                    end else begin
                        cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        state_r <= CAL;
                    end
                end
                RND: begin
                    rnd_p_r   <= rs_p_s;
                    rnd_ovf_r <= rs_ovf_s;
                    state_r   <= RESULT;
                end
                RESULT: begin
                    P       <= rnd_p_r;
                    Ovf     <= rnd_ovf_r;
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_128.sv
// Directed, table-driven bench for multiply_128 (Q57.70); expectations follow the
// MUL128_SAT_EN setting of the build.
module tb_multiply_128;

    localparam int W = 128;
`ifdef MUL128_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [W-1:0] ONE_Q = 128'd1 << 70;
    localparam logic [W-1:0] MAXP  = {1'b0, {127{1'b1}}};
    localparam logic [W-1:0] MINN  = {1'b1, {127{1'b0}}};

    logic         clk = 1'b0;
    logic         rst;
    logic         Start;
    logic [W-1:0] X, Y, P;
    logic         Busy, Done, Ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multiply_128 dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .X     (X),
        .Y     (Y),
        .P     (P),
        .Busy  (Busy),
        .Done  (Done),
        .Ovf   (Ovf)
    );

    typedef struct {
        string        name;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] p;
        logic         ovf;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction: Start for a single edge, then wait (bounded) for Done.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] p, output logic ovf,
                          output int lat, output int busy_bad);
        @(negedge clk);
        X = x; Y = y; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; X = ~x; Y = y ^ 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A;
        lat = 0; busy_bad = 0;
        if (!Busy) busy_bad++;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (Done) break;
            if (!Busy) busy_bad++;
        end
        p = P;
        ovf = Ovf;
    endtask

    initial begin
        logic [W-1:0] p;
        logic         ovf;
        int           lat, busy_bad, ndone, ke;

        vecs[0]  = '{"one_x_one",     ONE_Q,             ONE_Q,               ONE_Q,             1'b0};
        vecs[1]  = '{"neg1p5_x_2",    -(128'd3 << 69),   128'd1 << 71,        -(128'd3 << 70),   1'b0};
        vecs[2]  = '{"minneg_x_one",  MINN,              ONE_Q,               MINN,              1'b0};
        vecs[3]  = '{"tie_down",      128'd1,            128'd1 << 69,        128'd0,            1'b0};
        vecs[4]  = '{"tie_up",        128'd3,            128'd1 << 69,        128'd2,            1'b0};
        vecs[5]  = '{"above_half",    128'd1,            (128'd1 << 69) + 128'd1, 128'd1,        1'b0};
        vecs[6]  = '{"neg_tie",       -128'd3,           128'd1 << 69,        -128'd2,           1'b0};
        vecs[7]  = '{"neg_to_zero",   -128'd1,           128'd1 << 69,        128'd0,            1'b0};
        vecs[8]  = '{"zero_x",        128'd0,            -128'd5,             128'd0,            1'b0};
        vecs[9]  = '{"one_x_negone",  ONE_Q,             -ONE_Q,              -ONE_Q,            1'b0};
        vecs[10] = '{"q1p25_x_0p75",  128'd5 << 68,      128'd3 << 68,        128'd15 << 66,     1'b0};
        vecs[11] = '{"ovf_pos",       128'd1 << 120,     128'd1 << 120,       SAT ? MAXP : 128'd0, 1'b1};
        vecs[12] = '{"ovf_neg",       -(128'd1 << 120),  128'd1 << 120,       SAT ? MINN : 128'd0, 1'b1};
        vecs[13] = '{"minneg_x_neg1", MINN,              -ONE_Q,              SAT ? MAXP : MINN, 1'b1};
        vecs[14] = '{"y_zero",        -ONE_Q,            128'd0,              128'd0,            1'b0};

        rst = 1'b1; Start = 1'b0; X = '0; Y = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_p", P, 128'd0);
        check("reset_busy", {127'd0, Busy}, 128'd0);
        check("reset_done", {127'd0, Done}, 128'd0);
        check("reset_ovf", {127'd0, Ovf}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].x, vecs[i].y, p, ovf, lat, busy_bad);
            check($sformatf("%s_p", vecs[i].name), p, vecs[i].p);
            check($sformatf("%s_ovf", vecs[i].name), {127'd0, ovf}, {127'd0, vecs[i].ovf});
            check($sformatf("%s_latency", vecs[i].name), W'(lat), 128'd131);
            check($sformatf("%s_busy_gap", vecs[i].name), W'(busy_bad), 128'd0);
            check($sformatf("%s_busy_end", vecs[i].name), {127'd0, Busy}, 128'd0);
            @(posedge clk); #1;
            check($sformatf("%s_done_pulse", vecs[i].name), {127'd0, Done}, 128'd0);
        end

        // Reset during CAL iteration 50 (edge 52 after the accepted Start).
        @(negedge clk);
        X = 128'd3 << 70; Y = ONE_Q; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (51) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {127'd0, Busy}, 128'd0);
        check("abort_done", {127'd0, Done}, 128'd0);
        check("abort_p", P, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(ONE_Q, ONE_Q, p, ovf, lat, busy_bad);
        check("after_abort_p", p, ONE_Q);
        check("after_abort_latency", W'(lat), 128'd131);

        // Start held high with operands changing every cycle.
        ndone = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            X = W'(k % 7 + 1) << 70;
            Y = W'(k % 5 + 1) << 70;
            Start = 1'b1;
            @(posedge clk); #1;
            if (Done) begin
                ndone++;
                ke = k - 131;
                check($sformatf("hold_p_edge%0d", k), P, W'((ke % 7 + 1) * (ke % 5 + 1)) << 70);
            end
        end
        Start = 1'b0;
        check("hold_done_count", W'(ndone), 128'd2);
        lat = 0;
        while (lat < 200 && !Done) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_third_done", {127'd0, Done}, 128'd1);
        check("hold_third_p", P, W'((264 % 7 + 1) * (264 % 5 + 1)) << 70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
